fp_mul_result_stage: RTL
========================

// Module: fp_mul_result_stage
// PURPOSE
//  Downstream result stage for the IEEE-754 single-precision multiplier.
//  - Captures each {product, exception, overflow, underflow} from the multiplier with a valid/ready handshake.
//  - Buffers results in a DEPTH-entry FIFO.
//  - Tags each result with a NaN bit.
//  - Keeps sticky status flags and a completed-operation counter for the ALU writeback port.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CNT_W  16  width of op_count (and exc_count when enabled)
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      multiplier result valid
//  in_ready     out  1      stage can accept a result this cycle
//  in_product   in   32     IEEE-754 product {sign, exp[7:0], mant[22:0]}
//  in_exception in   1      multiplier exception flag
//  in_overflow  in   1      multiplier overflow flag
//  in_underflow in   1      multiplier underflow flag
//  out_valid    out  1      head entry valid
//  out_ready    in   1      consumer takes head entry
//  out_result   out  32     head entry product
//  out_flags    out  4      head entry flags {nan, exception, overflow, underflow}
//  flags_clr    in   1      clear sticky_flags
//  sticky_flags out  4      OR of flags of all accepted results since reset/clear, same order
//  op_count     out  CNT_W  number of results popped, saturating
//  exc_count    out  CNT_W  present only with FP_EXC_COUNT_EN
// BEHAVIOUR
//  - Reset: all pointers, count, sticky_flags, op_count and exc_count go to 0.
//    - out_valid = 0; out_result and out_flags = 0.
//    - in_ready = 0 while rst is high.
//  - Push: in_valid & in_ready.
//  - Pop: out_valid & out_ready.
//  - in_ready = !rst & (count != DEPTH).
//    - Full FIFO: no same-cycle pop bypass; in_ready stays 0 even if a pop occurs that cycle.
//  - out_valid = (count != 0). out_result and out_flags show the head entry, driven from registered storage.
//  - Latency: a result pushed in cycle N gives out_valid = 1 in cycle N+1 when the FIFO was empty.
//    - No combinational path from input to output.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//    - Pointers wrap modulo DEPTH.
//  - Empty FIFO: out_ready is ignored.
//  - Full FIFO: in_valid is ignored; data is not overwritten.
//  - nan tag, computed at push: in_product[30:23] == 8'hFF && in_product[22:0] != 0.
//  - Stored flags: {nan, in_exception, in_overflow, in_underflow}.
//  - sticky_flags update at push: sticky_flags <= (flags_clr ? 0 : sticky_flags) | pushed flags.
//    - A set in the same cycle as flags_clr wins, so no event is lost.
//  - op_count increments by 1 on each pop and saturates at 2^CNT_W-1 (no wrap).
//  - Reset mid-operation discards all buffered entries. The consumer sees out_valid = 0 in the cycle after rst.
//  - Input data is sampled only on push. Values on in_* while in_valid = 0 have no effect.
// CONFIGURATION
//  FP_EXC_COUNT_EN defined:
//    - Adds the exc_count port.
//    - exc_count increments on each pop whose head out_flags[2] (exception) = 1.
//    - Saturates at 2^CNT_W-1; reset to 0.
//  FP_EXC_COUNT_EN undefined:
//    - Port and counter logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset, then push 32'h40400000 (3.0), flags 0 -> next cycle out_valid = 1,
//     out_result = 32'h40400000, out_flags = 4'b0000. Pop -> op_count = 1.
//  2. Hold out_ready = 0 and push DEPTH = 4 results -> in_ready = 0 after the 4th push.
//     A 5th in_valid is not accepted. Then pop all 4 -> order is preserved; out_valid = 0 after the 4th pop.
//  3. Push 32'h7FC00000 with exception = 1 -> out_flags = 4'b1100, sticky_flags = 4'b1100.
//     Push 32'h7F800000, exception = 1, overflow = 1 -> nan = 0; sticky_flags = 4'b1110.
//  4. Assert flags_clr in the same cycle as a push with underflow = 1 -> sticky_flags = 4'b0001.
//     Assert flags_clr alone -> sticky_flags = 4'b0000.
//  5. Steady push + pop every cycle at half full for 20 cycles -> count is constant and pointers wrap.
//     op_count advances 20; no loss or duplication.
//  6. Assert rst with 3 entries buffered -> next cycle out_valid = 0, op_count = 0, sticky_flags = 0.
//     With FP_EXC_COUNT_EN, popping 2 exception entries gives exc_count = 2.

Source files
------------

// File: rtl/fp_mul_result_stage.sv
// fp_mul_result_stage
//   Result stage behind the IEEE-754 single-precision multiplier. It accepts
//   {product, exception, overflow, underflow} through a valid/ready handshake.
//   Each result is tagged with a NaN bit and held in a DEPTH-entry FIFO. The
//   stage also keeps sticky status flags and a saturating count of popped
//   results for the ALU writeback port.
//
//   Optional feature: define FP_EXC_COUNT_EN to add exc_count. It is a
//   saturating count of popped entries whose exception flag is set.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  input handshake; in_product, in_exception/overflow/underflow
//   out_valid/ready output handshake; out_result, out_flags {nan,exc,ovf,unf}
//   flags_clr       clears sticky_flags (a same-cycle push still sets bits)
//   sticky_flags    OR of the flags of all accepted results
//   op_count        number of popped results, saturating
//   exc_count       (FP_EXC_COUNT_EN only) number of popped exception results
module fp_mul_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_product,
  input  logic             in_exception,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  input  logic             flags_clr,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
`ifdef FP_EXC_COUNT_EN
  ,
  output logic [CNT_W-1:0] exc_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] product;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            push, pop, nan;
  logic [3:0]      in_flags;

  // A full FIFO does not bypass pops. in_ready depends only on state and rst.
  assign in_ready  = !rst && (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign nan      = (in_product[30:23] == 8'hFF) && (in_product[22:0] != 23'd0);
  assign in_flags = {nan, in_exception, in_overflow, in_underflow};

  // The storage is not reset. The head is masked while empty, so reset and
  // empty both read as zero.
  assign out_result = out_valid ? mem[rd_ptr].product : 32'd0;
  assign out_flags  = out_valid ? mem[rd_ptr].flags   : 4'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{flags: in_flags, product: in_product};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sticky_flags <= 4'd0;
      op_count     <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A set on the same cycle as a clear survives, so no event is lost.
      sticky_flags <= (flags_clr ? 4'd0 : sticky_flags) | (push ? in_flags : 4'd0);
      if (pop && op_count != '1) op_count <= op_count + 1'b1;
    end
  end

`ifdef FP_EXC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                 exc_count <= '0;
    else if (pop && out_flags[2] && exc_count != '1) exc_count <= exc_count + 1'b1;
  end
`endif

endmodule
